// File: rtl/msf_bram_write_scheduler.sv
// Shared BRAM write-port scheduler for the MSF decode path: arbitrates sample and
// minute-buffer writes, manages ping-pong banks and the PS minute-frame handshake.
module msf_bram_write_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int SEC_BASE = 0,
  parameter int MIN_BASE = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              one_sec_marker,
  input  logic              sec_req,
  input  logic [8:0]        sec_addr,
  input  logic [31:0]       sec_data,
  input  logic              min_req,
  input  logic [5:0]        min_second,
  input  logic [31:0]       min_data,
  input  logic              min_last,
  input  logic              frame_ack,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic              sec_bank,
  output logic              min_bank,
  output logic              frame_bank,
  output logic              frame_ready,
  output logic              frame_overrun,
  output logic [15:0]       drop_count
);

  typedef enum logic [1:0] {IDLE, WRITE_MIN, WRITE_SEC, COMMIT} state_t;

  state_t      state, state_next;

  logic        sec_pend;
  logic        sec_pend_bank;
  logic [8:0]  sec_pend_addr;
  logic [31:0] sec_pend_data;

  logic        min_pend;
  logic        min_pend_bank;
  logic        min_pend_last;
  logic [5:0]  min_pend_second;
  logic [31:0] min_pend_data;

  logic        sec_writing, min_writing;
  logic        sec_avail, min_avail;

  assign sec_writing = (state == WRITE_SEC);
  assign min_writing = (state == WRITE_MIN);

  // A request arriving this cycle counts as pending so the write lands next cycle.
  assign sec_avail = sec_req | (sec_pend & ~sec_writing);
  assign min_avail = min_req | (min_pend & ~min_writing);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, COMMIT: begin
        if (min_avail)      state_next = WRITE_MIN;
        else if (sec_avail) state_next = WRITE_SEC;
        else                state_next = IDLE;
      end
      WRITE_MIN: begin
        if (min_pend_last)  state_next = COMMIT;
        else if (sec_avail) state_next = WRITE_SEC;
        else                state_next = IDLE;
      end
      WRITE_SEC: begin
        if (min_avail)      state_next = WRITE_MIN;
        else if (sec_avail) state_next = WRITE_SEC;
        else                state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobe is masked during reset so a write in flight is abandoned immediately.
  always_comb begin
    bram_en   = 1'b0;
    bram_we   = 4'h0;
    bram_addr = '0;
    bram_din  = '0;
    if (!rst) begin
      case (state)
        WRITE_MIN: begin
          bram_en   = 1'b1;
          bram_we   = 4'hF;
          bram_addr = ADDR_W'(MIN_BASE + int'({min_pend_bank, min_pend_second}));
          bram_din  = min_pend_data;
        end
        WRITE_SEC: begin
          bram_en   = 1'b1;
          bram_we   = 4'hF;
          bram_addr = ADDR_W'(SEC_BASE + int'({sec_pend_bank, sec_pend_addr}));
          bram_din  = sec_pend_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sec_pend        <= 1'b0;
      sec_pend_bank   <= 1'b0;
      sec_pend_addr   <= '0;
      sec_pend_data   <= '0;
      min_pend        <= 1'b0;
      min_pend_bank   <= 1'b0;
      min_pend_last   <= 1'b0;
      min_pend_second <= '0;
      min_pend_data   <= '0;
      sec_bank        <= 1'b0;
      min_bank        <= 1'b0;
      frame_bank      <= 1'b0;
      frame_ready     <= 1'b0;
      frame_overrun   <= 1'b0;
      drop_count      <= '0;
    end else begin
      state <= state_next;

      if (sec_req) begin
        sec_pend      <= 1'b1;
        sec_pend_bank <= sec_bank;
        sec_pend_addr <= sec_addr;
        sec_pend_data <= sec_data;
        if (sec_pend && !sec_writing && drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end else if (sec_writing) begin
        sec_pend <= 1'b0;
      end

      if (min_req) begin
        min_pend        <= 1'b1;
        min_pend_bank   <= min_bank;
        min_pend_second <= min_second;
        min_pend_data   <= min_data;
        min_pend_last   <= min_last;
      end else if (min_writing) begin
        min_pend <= 1'b0;
      end

      if (one_sec_marker)
        sec_bank <= ~sec_bank;

      // Commit takes precedence over a coincident ack.
      if (state == COMMIT) begin
        frame_bank  <= min_bank;
        min_bank    <= ~min_bank;
        frame_ready <= 1'b1;
        if (frame_ready && !frame_ack)
          frame_overrun <= 1'b1;
      end else if (frame_ack) begin
        frame_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_msf_bram_write_scheduler.sv
// Directed self-checking bench for msf_bram_write_scheduler.
module tb_msf_bram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        one_sec_marker;
  logic        sec_req;
  logic [8:0]  sec_addr;
  logic [31:0] sec_data;
  logic        min_req;
  logic [5:0]  min_second;
  logic [31:0] min_data;
  logic        min_last;
  logic        frame_ack;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [10:0] bram_addr;
  logic [31:0] bram_din;
  logic        sec_bank;
  logic        min_bank;
  logic        frame_bank;
  logic        frame_ready;
  logic        frame_overrun;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  msf_bram_write_scheduler #(.ADDR_W(11), .SEC_BASE(0), .MIN_BASE(1024)) dut (
    .clk(clk), .rst(rst), .one_sec_marker(one_sec_marker),
    .sec_req(sec_req), .sec_addr(sec_addr), .sec_data(sec_data),
    .min_req(min_req), .min_second(min_second), .min_data(min_data),
    .min_last(min_last), .frame_ack(frame_ack),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .sec_bank(sec_bank), .min_bank(min_bank), .frame_bank(frame_bank),
    .frame_ready(frame_ready), .frame_overrun(frame_overrun), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    one_sec_marker = 1'b0; sec_req = 1'b0; sec_addr = '0; sec_data = '0;
    min_req = 1'b0; min_second = '0; min_data = '0; min_last = 1'b0; frame_ack = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_din} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bram: en=%b we=%h addr=%0d din=%h, required all 0",
               bram_en, bram_we, bram_addr, bram_din);
    end
    checks++;
    if ({sec_bank, min_bank, frame_bank, frame_ready, frame_overrun, drop_count} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_status: banks=%b%b%b ready=%b ovr=%b drops=%0d, required all 0",
               sec_bank, min_bank, frame_bank, frame_ready, frame_overrun, drop_count);
    end
    rst = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_sample_only();
    sec_req = 1'b1; sec_addr = 9'd5; sec_data = 32'hA5A5_0001;
    tick();
    sec_req = 1'b0;
    checks++;
    if (bram_en !== 1'b1 || bram_we !== 4'hF || bram_addr !== 11'd5 || bram_din !== 32'hA5A5_0001) begin
      failures++;
      $display("[TB] FAIL sample_write: en=%b we=%h addr=%0d din=%h, required en=1 we=F addr=5 din=a5a50001",
               bram_en, bram_we, bram_addr, bram_din);
    end
    tick();
    checks++;
    if (bram_en !== 1'b0 || bram_we !== 4'h0) begin
      failures++;
      $display("[TB] FAIL sample_single_strobe: en=%b we=%h, required en=0 we=0", bram_en, bram_we);
    end
    repeat (3) tick();
  endtask

  task automatic test_collision();
    sec_req = 1'b1; sec_addr = 9'd7; sec_data = 32'h0000_0077;
    min_req = 1'b1; min_second = 6'd12; min_data = 32'd3; min_last = 1'b0;
    tick();
    sec_req = 1'b0; min_req = 1'b0;
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd1036 || bram_din !== 32'd3) begin
      failures++;
      $display("[TB] FAIL collision_min_first: en=%b addr=%0d din=%h, required en=1 addr=1036 din=3",
               bram_en, bram_addr, bram_din);
    end
    tick();
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd7 || bram_din !== 32'h77) begin
      failures++;
      $display("[TB] FAIL collision_sec_second: en=%b addr=%0d din=%h, required en=1 addr=7 din=77",
               bram_en, bram_addr, bram_din);
    end
    tick();
    checks++;
    if (bram_en !== 1'b0 || drop_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL collision_after: en=%b drops=%0d, required en=0 drops=0", bram_en, drop_count);
    end
    repeat (3) tick();
  endtask

  task automatic test_drop();
    sec_req = 1'b1; sec_addr = 9'd8; sec_data = 32'h0000_0088;
    min_req = 1'b1; min_second = 6'd13; min_data = 32'h0000_000D; min_last = 1'b0;
    tick();
    min_req = 1'b0;
    sec_addr = 9'd9; sec_data = 32'h0000_0099;
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd1037) begin
      failures++;
      $display("[TB] FAIL drop_min_write: en=%b addr=%0d, required en=1 addr=1037", bram_en, bram_addr);
    end
    tick();
    sec_req = 1'b0;
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd9 || bram_din !== 32'h99) begin
      failures++;
      $display("[TB] FAIL drop_replacement: en=%b addr=%0d din=%h, required en=1 addr=9 din=99",
               bram_en, bram_addr, bram_din);
    end
    tick();
    checks++;
    if (bram_en !== 1'b0 || drop_count !== 16'd1) begin
      failures++;
      $display("[TB] FAIL drop_count: en=%b drops=%0d, required en=0 drops=1", bram_en, drop_count);
    end
    repeat (3) tick();
  endtask

  task automatic test_bank_swap();
    int bad = 0;
    for (int i = 0; i < 470; i++) begin
      sec_req = 1'b1; sec_addr = 9'(i); sec_data = 32'h5000_0000 | 32'(i);
      tick();
      sec_req = 1'b0;
      checks++;
      if (bram_en !== 1'b1 || bram_addr !== 11'(i) || bram_din !== (32'h5000_0000 | 32'(i))) begin
        failures++;
        if (bad < 5)
          $display("[TB] FAIL bank0_sample_%0d: en=%b addr=%0d din=%h, required en=1 addr=%0d din=%h",
                   i, bram_en, bram_addr, bram_din, i, 32'h5000_0000 | 32'(i));
        bad++;
      end
      repeat (164) tick();
    end
    one_sec_marker = 1'b1;
    tick();
    one_sec_marker = 1'b0;
    checks++;
    if (sec_bank !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bank_toggle: sec_bank=%b, required 1", sec_bank);
    end
    sec_req = 1'b1; sec_addr = 9'd3; sec_data = 32'h6000_0003;
    tick();
    sec_req = 1'b0;
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd515) begin
      failures++;
      $display("[TB] FAIL bank1_sample: en=%b addr=%0d, required en=1 addr=515", bram_en, bram_addr);
    end
    repeat (3) tick();
    // Marker coincident with a request: the request keeps the old bank.
    one_sec_marker = 1'b1; sec_req = 1'b1; sec_addr = 9'd10; sec_data = 32'h6000_000A;
    tick();
    one_sec_marker = 1'b0; sec_req = 1'b0;
    checks++;
    if (bram_en !== 1'b1 || bram_addr !== 11'd522 || sec_bank !== 1'b0) begin
      failures++;
      $display("[TB] FAIL marker_with_req: en=%b addr=%0d sec_bank=%b, required en=1 addr=522 sec_bank=0",
               bram_en, bram_addr, sec_bank);
    end
    repeat (3) tick();
  endtask

  task automatic run_minute(input logic bank, input string tag);
    int bad = 0;
    for (int s = 0; s < 60; s++) begin
      min_req = 1'b1; min_second = 6'(s); min_data = 32'h0000_0100 + 32'(s);
      min_last = (s == 59);
      tick();
      min_req = 1'b0; min_last = 1'b0;
      checks++;
      if (bram_en !== 1'b1 || bram_addr !== 11'(1024 + (bank ? 64 : 0) + s) ||
          bram_din !== 32'h0000_0100 + 32'(s)) begin
        failures++;
        if (bad < 5)
          $display("[TB] FAIL %s_second_%0d: en=%b addr=%0d din=%h, required en=1 addr=%0d din=%h",
                   tag, s, bram_en, bram_addr, bram_din, 1024 + (bank ? 64 : 0) + s,
                   32'h0000_0100 + 32'(s));
        bad++;
      end
      tick();
    end
  endtask

  task automatic test_minute_commit();
    run_minute(1'b0, "minute0");
    // The tick after the second-59 write cycle is the commit cycle.
    checks++;
    if (bram_en !== 1'b0 || frame_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL commit_cycle: en=%b ready=%b, required en=0 ready=0", bram_en, frame_ready);
    end
    tick();
    checks++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || min_bank !== 1'b1 || frame_overrun !== 1'b0) begin
      failures++;
      $display("[TB] FAIL commit_flags: ready=%b frame_bank=%b min_bank=%b ovr=%b, required 1 0 1 0",
               frame_ready, frame_bank, min_bank, frame_overrun);
    end
    repeat (2) tick();
  endtask

  task automatic test_overrun_ack();
    run_minute(1'b1, "minute1");
    tick();
    checks++;
    if (frame_overrun !== 1'b1 || frame_bank !== 1'b1 || min_bank !== 1'b0 || frame_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_flags: ovr=%b frame_bank=%b min_bank=%b ready=%b, required 1 1 0 1",
               frame_overrun, frame_bank, min_bank, frame_ready);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    checks++;
    if (frame_ready !== 1'b0 || frame_overrun !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ack_clear: ready=%b ovr=%b, required ready=0 ovr=1", frame_ready, frame_overrun);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_midstream();
    sec_req = 1'b1; sec_addr = 9'd20; sec_data = 32'hDEAD_0020;
    min_req = 1'b1; min_second = 6'd30; min_data = 32'hDEAD_0030; min_last = 1'b0;
    tick();
    sec_req = 1'b0; min_req = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (bram_en !== 1'b0 || bram_we !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_cycle_write: en=%b we=%h, required en=0 we=0", bram_en, bram_we);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bram_en, bram_we, bram_addr, bram_din, sec_bank, min_bank, frame_bank,
         frame_ready, frame_overrun, drop_count} !== '0) begin
      failures++;
      $display("[TB] FAIL post_reset_outputs: en=%b addr=%0d ready=%b ovr=%b drops=%0d min_bank=%b frame_bank=%b, required all 0",
               bram_en, bram_addr, frame_ready, frame_overrun, drop_count, min_bank, frame_bank);
    end
    tick();
    checks++;
    if (bram_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abandoned_pending: en=%b addr=%0d, required en=0", bram_en, bram_addr);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_sample_only();
    test_collision();
    test_drop();
    test_bank_swap();
    test_minute_commit();
    test_overrun_ack();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/msf_bram_write_scheduler.md
Name: msf_bram_write_scheduler

Overview:
- Schedules and arbitrates all writes from the MSF timing/decode path onto one shared 32-bit BRAM write port.
- Two write sources share the port: per-carrier-sample second-buffer writes, and per-second decoded-bit minute-buffer writes.
- Manages ping-pong banks for both buffers and raises a minute-frame-ready flag, handshaked with the PS.

Parameters:
ADDR_W, 11, BRAM word address width
SEC_BASE, 0, word base of second buffer (2 banks x 512 words)
MIN_BASE, 1024, word base of minute buffer (2 banks x 64 words)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
one_sec_marker  in  1  one-cycle pulse at second boundary; swaps second bank
sec_req  in  1  one-cycle pulse: write sample
sec_addr  in  9  sample index within second
sec_data  in  32  sample word
min_req  in  1  one-cycle pulse: write decoded second
min_second  in  6  second index 0..60
min_data  in  32  decoded bits/status word
min_last  in  1  qualifies min_req: last second of minute
frame_ack  in  1  PS pulse: frame consumed
bram_en  out  1  write strobe
bram_we  out  4  byte enables
bram_addr  out  ADDR_W  word address
bram_din  out  32  write data
sec_bank  out  1  second bank currently being filled
min_bank  out  1  minute bank currently being filled
frame_bank  out  1  bank holding last completed minute
frame_ready  out  1  completed minute awaiting ack
frame_overrun  out  1  sticky: minute completed while frame_ready high
drop_count  out  16  sample writes lost, saturating

Behaviour:
- Reset: all outputs 0; pending flags cleared; FSM to IDLE. Reset mid-write abandons any pending request; no BRAM write occurs in the reset cycle or the cycle after.
- Capture: sec_req latches {sec_bank, sec_addr, sec_data} into sec_pend. min_req latches {min_bank, min_second, min_data, min_last} into min_pend. Bank is latched at capture; a later swap does not redirect a pending write.
- FSM states: IDLE, WRITE_MIN, WRITE_SEC, COMMIT.
  - IDLE -> WRITE_MIN if min_pend, else WRITE_SEC if sec_pend.
  - WRITE_MIN -> COMMIT if latched min_last, else WRITE_SEC if sec_pend, else IDLE.
  - WRITE_SEC -> WRITE_MIN if min_pend, else WRITE_SEC if sec_pend, else IDLE.
  - COMMIT -> same choice as IDLE.
- Priority: minute over sample.
- Write cycle: bram_en=1, bram_we=4'hF for exactly one cycle in WRITE_MIN/WRITE_SEC; otherwise bram_en=0 and bram_we=0.
  - Sample address: SEC_BASE + {bank, sec_addr}.
  - Minute address: MIN_BASE + {bank, min_second}.
  - Truncate to ADDR_W.
- Latency: request at cycle N with no contention -> write at N+1. Both requests at N -> minute at N+1, sample at N+2.
- Overwrite: sec_req while sec_pend is still unwritten -> new request replaces old, drop_count+1 (saturates at 16'hFFFF). Same for min_req, with no count. A pending flag whose write occurs in the same cycle as a new request re-arms without a drop.
- one_sec_marker: sec_bank toggles on the following cycle. A simultaneous sec_req captures the old bank.
- COMMIT, one cycle with no BRAM write:
  - frame_bank <= min_bank; min_bank toggles; frame_ready <= 1.
  - If frame_ready was already 1 and no frame_ack that cycle -> frame_overrun <= 1; frame_bank still updates.
- frame_ack clears frame_ready. frame_ack in the COMMIT cycle: commit wins, frame_ready stays 1, no overrun.
- frame_overrun and drop_count are cleared only by rst.
- min_second > 60: the write is still performed at the computed address; no check.

Test Plan:
- Sample only: rst 3 cycles, sec_req at cycle 10 with sec_addr=5, data=32'hA5A5_0001 -> cycle 11: bram_en=1, we=F, addr=5, din=A5A50001; no other strobes.
- Collision: sec_req (addr 7) and min_req (second 12, data 3) in the same cycle -> minute write at addr 1024+12=1036 next cycle, sample write at addr 7 one cycle later; drop_count=0.
- Drop: sec_req and min_req at cycle N, second sec_req at N+1 (addr 9) -> only addr 9 written at N+2; drop_count=1.
- Bank swap: 165-cycle sample cadence (164 low + 1 pulse), one_sec_marker after 470 samples -> sec_bank=1; next sample writes addr 512+idx.
- Minute commit: min_req for seconds 0..59, min_last on 59 -> COMMIT after the second-59 write; frame_ready=1, frame_bank=0, min_bank=1; the next minute's second 0 writes addr 1088.
- Overrun/ack: second minute completes without frame_ack -> frame_overrun=1, frame_bank=1. Then rst mid-stream with sec_pend set -> no write; all outputs 0.
